// File: rtl/qos_txn_scheduler.sv
// qos_txn_scheduler: holds up to NUM_ID pending transactions indexed by ID,
// issues them one at a time through a single issue register (highest QoS
// first, round-robin among equal QoS), tracks issued IDs until completion
// and reports the max QoS over all live IDs.
// Optional build macro QOS_SCHED_AGING_EN: a slot that has waited AGE_LIMIT
// cycles competes one QoS level higher (selection only).
//
// Handshakes (req_*, iss_*): valid/ready. A transfer happens on a rising clk
// edge where valid && ready are both high; the offering side keeps valid and
// payload stable until that edge. cpl_vld is a single-cycle strobe with no
// back-pressure.
module qos_txn_scheduler #(
  parameter int NUM_ID    = 16,
  parameter int ID_W      = 4,
  parameter int QOS_W     = 3,
  parameter int AGE_LIMIT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_vld,
  input  logic [ID_W-1:0]  req_id,
  input  logic [QOS_W-1:0] req_qos,
  output logic             req_rdy,
  output logic             iss_vld,
  output logic [ID_W-1:0]  iss_id,
  output logic [QOS_W-1:0] iss_qos,
  input  logic             iss_rdy,
  input  logic             cpl_vld,
  input  logic [ID_W-1:0]  cpl_id,
  output logic [QOS_W-1:0] o_max_qos,
  output logic             err
);

  typedef enum logic [1:0] {
    SLOT_IDLE = 2'd0,
    SLOT_WAIT = 2'd1,
    SLOT_OUT  = 2'd2
  } slot_state_e;

  // Elaboration-time sanity check of the parameter set.
  if ((1 << ID_W) != NUM_ID || AGE_LIMIT < 1) begin : g_param_check
    $error("qos_txn_scheduler: inconsistent NUM_ID/ID_W or AGE_LIMIT < 1");
  end

  slot_state_e      slot_state_q [NUM_ID];
  slot_state_e      slot_state_d [NUM_ID];
  logic [QOS_W-1:0] qos_q        [NUM_ID];
  logic [QOS_W-1:0] qos_d        [NUM_ID];
  logic [QOS_W-1:0] eff_qos      [NUM_ID];
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic             iss_vld_q, iss_vld_d;
  logic [ID_W-1:0]  iss_id_q, iss_id_d;
  logic [QOS_W-1:0] iss_qos_q, iss_qos_d;
  logic             err_q, err_d;

  logic             accept;
  logic             load;
  logic             sel_found;
  logic [ID_W-1:0]  sel_id;
  logic [ID_W-1:0]  scan_id;
  logic [QOS_W-1:0] sel_eff;
  logic [QOS_W-1:0] max_qos;

  assign req_rdy   = (slot_state_q[req_id] == SLOT_IDLE);
  assign accept    = req_vld && req_rdy;
  assign load      = (!iss_vld_q || iss_rdy) && sel_found;
  assign iss_vld   = iss_vld_q;
  assign iss_id    = iss_id_q;
  assign iss_qos   = iss_qos_q;
  assign err       = err_q;
  assign o_max_qos = max_qos;

`ifdef QOS_SCHED_AGING_EN
  localparam int AGE_W = $clog2(AGE_LIMIT + 1);

  logic [AGE_W-1:0] age_q [NUM_ID];
  logic [AGE_W-1:0] age_d [NUM_ID];

  // Effective QoS: a fully aged slot competes one level higher, capped at max.
  always_comb begin
    for (int i = 0; i < NUM_ID; i++) begin
      if (age_q[i] == AGE_W'(AGE_LIMIT) && qos_q[i] != '1) eff_qos[i] = qos_q[i] + QOS_W'(1);
      else eff_qos[i] = qos_q[i];
    end
  end

  // Wait counters: cleared on accept, count up while the slot stays WAIT.
  always_comb begin
    for (int i = 0; i < NUM_ID; i++) begin
      age_d[i] = age_q[i];
      if (accept && req_id == ID_W'(i)) begin
        age_d[i] = '0;
      end else if (slot_state_q[i] == SLOT_WAIT && !(load && sel_id == ID_W'(i))
                   && age_q[i] != AGE_W'(AGE_LIMIT)) begin
        age_d[i] = age_q[i] + AGE_W'(1);
      end
    end
  end

  // Wait counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ID; i++) age_q[i] <= '0;
    end else begin
      age_q <= age_d;
    end
  end
`else
  // Without aging the stored QoS is the selection QoS.
  always_comb begin
    for (int i = 0; i < NUM_ID; i++) eff_qos[i] = qos_q[i];
  end
`endif

  // Winner: highest effective QoS among WAIT slots; strict '>' while scanning
  // upward from rr_ptr keeps the first equal-QoS slot, giving round-robin.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    sel_eff   = '0;
    scan_id   = '0;
    for (int k = 0; k < NUM_ID; k++) begin
      scan_id = rr_ptr_q + ID_W'(k);
      if (slot_state_q[scan_id] == SLOT_WAIT && (!sel_found || eff_qos[scan_id] > sel_eff)) begin
        sel_found = 1'b1;
        sel_id    = scan_id;
        sel_eff   = eff_qos[scan_id];
      end
    end
  end

  // Max stored (unaged) QoS over live slots.
  always_comb begin
    max_qos = '0;
    for (int i = 0; i < NUM_ID; i++) begin
      if (slot_state_q[i] != SLOT_IDLE && qos_q[i] > max_qos) max_qos = qos_q[i];
    end
  end

  // Next state: accept, issue-register load and completion act on distinct
  // slots (IDLE, WAIT, OUT respectively), so their order here is irrelevant.
  always_comb begin
    slot_state_d = slot_state_q;
    qos_d        = qos_q;
    rr_ptr_d     = rr_ptr_q;
    iss_vld_d    = iss_vld_q;
    iss_id_d     = iss_id_q;
    iss_qos_d    = iss_qos_q;
    err_d        = err_q;

    if (accept) begin
      slot_state_d[req_id] = SLOT_WAIT;
      qos_d[req_id]        = req_qos;
    end

    if (load) begin
      slot_state_d[sel_id] = SLOT_OUT;
      iss_vld_d            = 1'b1;
      iss_id_d             = sel_id;
      iss_qos_d            = qos_q[sel_id];
      rr_ptr_d             = sel_id + ID_W'(1);
    end else if (iss_rdy) begin
      iss_vld_d = 1'b0;
    end

    if (cpl_vld) begin
      if (slot_state_q[cpl_id] == SLOT_OUT) slot_state_d[cpl_id] = SLOT_IDLE;
      else err_d = 1'b1;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ID; i++) begin
        slot_state_q[i] <= SLOT_IDLE;
        qos_q[i]        <= '0;
      end
      rr_ptr_q  <= '0;
      iss_vld_q <= 1'b0;
      iss_id_q  <= '0;
      iss_qos_q <= '0;
      err_q     <= 1'b0;
    end else begin
      slot_state_q <= slot_state_d;
      qos_q        <= qos_d;
      rr_ptr_q     <= rr_ptr_d;
      iss_vld_q    <= iss_vld_d;
      iss_id_q     <= iss_id_d;
      iss_qos_q    <= iss_qos_d;
      err_q        <= err_d;
    end
  end

endmodule
